// File: rtl/i2c_target_regfile.sv
// I2C target exposing an NREGS x 8 register file: first written byte is the pointer, then data.
// Optional feature: define I2C_TARGET_AUTOINC_EN to advance the pointer after every data byte.
module i2c_target_regfile #(
    parameter logic [6:0]  DEV_ADDR = 7'h39,
    parameter int unsigned NREGS    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe_o,
    input  logic [$clog2(NREGS)-1:0] rd_addr_i,
    output logic [7:0]               rd_data_o,
    output logic                     wr_stb_o,
    output logic [$clog2(NREGS)-1:0] wr_addr_o,
    output logic                     busy_o
);
    localparam int unsigned AW = $clog2(NREGS);
`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StNomatch
    } state_e;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    // Reset to the idle bus level so leaving reset never looks like a START.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    state_e        state_q, state_d;
    logic [7:0]    rx_q, rx_d, tx_q, tx_d, rx_shift;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [AW-1:0] ptr_q, ptr_d, ptr_next;
    logic          rw_q, rw_d;
    logic          mack_q, mack_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_en;
    logic [7:0]    regs_q [NREGS];
    logic [7:0]    cur_byte;
    logic [7:0]    rd_data_q;
    logic          wr_stb_q;
    logic [AW-1:0] wr_addr_q;

    assign rx_shift = {rx_q[6:0], sda_s};
    assign ptr_next = AutoInc ? ptr_q + AW'(1) : ptr_q;
    assign cur_byte = regs_q[ptr_q];

    always_comb begin
        state_d   = state_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        bit_cnt_d = bit_cnt_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        mack_d    = mack_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_en     = 1'b0;

        if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        rx_d      = rx_shift;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (rx_q[7:1] == DEV_ADDR) begin
                            state_d  = StAddrAck;
                            sda_oe_d = 1'b1;
                            rw_d     = rx_q[0];
                            busy_d   = 1'b1;
                        end else begin
                            state_d = StNomatch;
                            busy_d  = 1'b0;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            state_d  = StRdata;
                            tx_d     = cur_byte;
                            sda_oe_d = ~cur_byte[7];
                        end else begin
                            state_d  = StPtr;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                StPtr: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        rx_d      = rx_shift;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        ptr_d     = rx_q[AW-1:0];
                        state_d   = StPtrAck;
                        sda_oe_d  = 1'b1;
                    end
                end
                StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        state_d  = StWdata;
                        sda_oe_d = 1'b0;
                    end
                end
                StWdata: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        rx_d      = rx_shift;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Commit on the 8th rise so a STOP/START mid-byte writes nothing.
                        if (bit_cnt_q == 4'd7) begin
                            wr_en = 1'b1;
                            ptr_d = ptr_next;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        state_d   = StWdataAck;
                        sda_oe_d  = 1'b1;
                    end
                end
                StRdata: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            ptr_d = ptr_next;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = '0;
                            state_d   = StRdataAck;
                            sda_oe_d  = 1'b0;
                        end else if (bit_cnt_q != 4'd0) begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                StRdataAck: begin
                    if (scl_rise) begin
                        mack_d = ~sda_s;
                    end else if (scl_fall) begin
                        if (mack_q) begin
                            state_d  = StRdata;
                            tx_d     = cur_byte;
                            sda_oe_d = ~cur_byte[7];
                        end else begin
                            // NACK: stay off the bus until STOP or START, still busy.
                            state_d  = StNomatch;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            rx_q      <= '0;
            tx_q      <= '0;
            bit_cnt_q <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            mack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            regs_q[ptr_q] <= rx_shift;
        end
    end

    // A same-cycle bus write to the locally read register is forwarded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= 8'h00;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            rd_data_q <= (wr_en && ptr_q == rd_addr_i) ? rx_shift : regs_q[rd_addr_i];
            wr_stb_q  <= wr_en;
            if (wr_en) begin
                wr_addr_q <= ptr_q;
            end
        end
    end

    assign sda_oe_o  = sda_oe_q;
    assign busy_o    = busy_q;
    assign rd_data_o = rd_data_q;
    assign wr_stb_o  = wr_stb_q;
    assign wr_addr_o = wr_addr_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C controller, register-file model and write scoreboard.
// Follows I2C_TARGET_AUTOINC_EN the same way the design does.
module tb_i2c_target_regfile;
    localparam logic [6:0] DEV   = 7'h39;
    localparam int         NREGS = 16;
    localparam int         AW    = $clog2(NREGS);
    localparam int         Q     = 8;
`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;
    typedef logic [7:0] bytes_t [$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m_scl = 1'b1;
    logic          m_sda = 1'b1;
    logic          sda_bus;
    logic [AW-1:0] rd_addr = '0;
    logic          sda_oe, wr_stb, busy;
    logic [7:0]    rd_data;
    logic [AW-1:0] wr_addr;

    wr_t           exp_wr [$];
    logic [7:0]    mregs [NREGS];
    int unsigned   mptr = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            n_stb = 0;
    bit            quiet = 1'b0;
    int            quiet_viol = 0;

    assign sda_bus = m_sda & ~sda_oe;
    always #5 clk = ~clk;

    i2c_target_regfile #(
        .DEV_ADDR(DEV),
        .NREGS   (NREGS)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .scl_i    (m_scl),
        .sda_i    (sda_bus),
        .sda_oe_o (sda_oe),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data),
        .wr_stb_o (wr_stb),
        .wr_addr_o(wr_addr),
        .busy_o   (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (wr_stb) begin
                n_stb++;
                if (exp_wr.size() == 0) begin
                    check("wr_stb_spurious", 32'(wr_stb), 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    if (rd_addr == e.addr) check("wr_fwd_rd_data", 32'(rd_data), 32'(e.data));
                end
            end
            if (quiet && (sda_oe || busy)) quiet_viol++;
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        b = sda_bus; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    task automatic check_reg(input int a, input logic [7:0] exp);
        rd_addr = AW'(a);
        @(negedge clk);
        check("rd_data", 32'(rd_data), 32'(exp));
    endtask

    task automatic write_txn(input logic [7:0] ptr, input bytes_t data, input bit do_stop);
        logic ack;
        bus_start();
        send_byte({DEV, 1'b0}, ack);
        check("wr_addr_ack", 32'(ack), 32'd1);
        check("busy_addressed", 32'(busy), 32'd1);
        send_byte(ptr, ack);
        check("ptr_ack", 32'(ack), 32'd1);
        mptr = ptr % NREGS;
        foreach (data[i]) begin
            exp_wr.push_back('{addr: AW'(mptr), data: data[i]});
            mregs[mptr] = data[i];
            send_byte(data[i], ack);
            check("data_ack", 32'(ack), 32'd1);
            if (AUTOINC) mptr = (mptr + 1) % NREGS;
        end
        if (do_stop) bus_stop();
    endtask

    // Repeated START + read of n bytes from the model pointer; last byte NACKed.
    task automatic read_txn(input int n);
        logic       ack;
        logic [7:0] got, exp;
        bus_start();
        send_byte({DEV, 1'b1}, ack);
        check("rd_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            exp = mregs[mptr];
            recv_byte(got, (i < n - 1));
            check("rd_byte", 32'(got), 32'(exp));
            if (AUTOINC) mptr = (mptr + 1) % NREGS;
        end
        wait_q();
        check("nack_released", 32'(sda_oe), 32'd0);
        bus_stop();
        check("busy_after_stop", 32'(busy), 32'd0);
    endtask

    initial begin
        bytes_t     d;
        logic       ack, b;
        int         s0, p, n, a;
        for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single write: 0x72, 0x03, 0xA5
        rd_addr = AW'(3);
        s0 = n_stb;
        d.delete(); d.push_back(8'hA5);
        write_txn(8'h03, d, 1'b1);
        check("t1_stb_count", n_stb - s0, 1);
        check_reg(3, mregs[3]);
        check("t1_busy", 32'(busy), 32'd0);

        // Pointer 0x0F then two bytes (wraps with auto-increment)
        rd_addr = AW'(0);
        d.delete(); d.push_back(8'h11); d.push_back(8'h22);
        write_txn(8'h0F, d, 1'b1);
        check_reg(15, mregs[15]);
        check_reg(0, mregs[0]);

        // Pointer write, repeated START, read two bytes
        d.delete(); d.push_back(8'h3C);
        write_txn(8'h04, d, 1'b1);
        d.delete();
        write_txn(8'h03, d, 1'b0);
        read_txn(2);

        // Wrong address: no ACK, no bus activity, no writes
        quiet = 1'b1;
        s0 = n_stb;
        bus_start();
        send_byte(8'h70, ack);
        check("nomatch_ack", 32'(ack), 32'd0);
        send_byte(8'h04, ack);
        send_byte(8'h99, ack);
        bus_stop();
        quiet = 1'b0;
        check("nomatch_quiet", quiet_viol, 0);
        check("nomatch_stb", n_stb - s0, 0);
        check_reg(4, mregs[4]);

        // STOP after four data bits
        rd_addr = AW'(2);
        s0 = n_stb;
        bus_start();
        send_byte({DEV, 1'b0}, ack);
        check("midstop_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h02, ack);
        check("midstop_ptr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        check("midstop_busy", 32'(busy), 32'd0);
        check("midstop_sda_oe", 32'(sda_oe), 32'd0);
        check("midstop_stb", n_stb - s0, 0);
        check_reg(2, mregs[2]);

        // Randomized write/read transactions
        for (int k = 0; k < 6; k++) begin
            p = $urandom_range(0, 255);
            n = $urandom_range(1, 3);
            d.delete();
            for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
            rd_addr = AW'(p % NREGS);
            write_txn(8'(p), d, 1'b1);
            d.delete();
            write_txn(8'($urandom_range(0, 255)), d, 1'b0);
            read_txn($urandom_range(1, 3));
            a = $urandom_range(0, NREGS - 1);
            check_reg(a, mregs[a]);
        end

        // Reset during the 4th bit (a 0) of a read of 0xA5
        d.delete(); d.push_back(8'hA5);
        write_txn(8'h03, d, 1'b1);
        d.delete();
        write_txn(8'h03, d, 1'b0);
        bus_start();
        send_byte({DEV, 1'b1}, ack);
        check("rstread_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) recv_bit(b);
        m_sda = 1'b1;
        wait_q();
        check("rstread_pre_oe", 32'(sda_oe), 32'd1);
        m_scl = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstread_oe_now", 32'(sda_oe), 32'd0);
        check("rstread_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
        mptr = 0;
        m_scl = 1'b0;
        wait_q();
        bus_stop();
        check("rstread_idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NREGS; i++) check_reg(i, mregs[i]);

        // Bus still usable after reset
        rd_addr = AW'(7);
        d.delete(); d.push_back(8'h5A);
        write_txn(8'h07, d, 1'b1);
        check_reg(7, mregs[7]);

        repeat (4) @(negedge clk);
        check("wr_pending", exp_wr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h39, the 7-bit device address this target answers to.
REQ-002 SHALL have parameter NREGS, default 16, the register count; it SHALL be a power of two, 2..256.
REQ-003 SHALL have port clk_i, input, 1, the single system clock; clk_i SHALL be at least 16x the SCL frequency.
REQ-004 SHALL have port rst_i, input, 1, the asynchronous active-high reset.
REQ-005 SHALL have port scl_i, input, 1, the I2C clock from the bus (asynchronous).
REQ-006 SHALL have port sda_i, input, 1, the I2C data from the bus (asynchronous).
REQ-007 SHALL have port sda_oe_o, output, 1; 1 pulls SDA low, 0 releases SDA (open drain, never drives high).
REQ-008 SHALL have port rd_addr_i, input, $clog2(NREGS), the local read address.
REQ-009 SHALL have port rd_data_o, output, 8, the register at rd_addr_i, registered with 1-cycle latency.
REQ-010 SHALL have port wr_stb_o, output, 1, a 1-cycle pulse for each bus byte written to the register file.
REQ-011 SHALL have port wr_addr_o, output, $clog2(NREGS), the register written when wr_stb_o pulses.
REQ-012 SHALL have port busy_o, output, 1, high from an addressed START until STOP or address mismatch.

Function
REQ-013 SHALL pass scl_i and sda_i through 2-flop synchronizers and detect edges from the synchronized values only.
REQ-014 SHALL detect START as synced SDA 1->0 while synced SCL is 1, and STOP as synced SDA 0->1 while synced SCL is 1.
REQ-015 SHALL sample SDA on each detected SCL rising edge and update sda_oe_o 1 cycle after each detected SCL falling edge.
REQ-016 SHALL use states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, NOMATCH.
REQ-017 SHALL move to ADDR on START from any state, including a repeated START, and shift in 7 address bits plus the R/W bit.
REQ-018 SHALL go to ADDR_ACK and pull SDA low for the 9th clock if the address matches; on a mismatch it SHALL go to NOMATCH, keep SDA released and wait for START.
REQ-019 SHALL go after the ADDR ACK to PTR when W, or to RDATA when R, with the first bit on SDA before the next SCL rise.
REQ-020 SHALL ACK the first written byte as the register pointer (modulo NREGS), then take each following byte through WDATA and WDATA_ACK.
REQ-021 SHALL write each data byte to reg[pointer] at its 8th SCL rise, pulse wr_stb_o, and ACK it.
REQ-022 SHALL shift out reg[pointer] MSB first in RDATA, with sda_oe_o = ~bit, and SHALL release SDA in RDATA_ACK.
REQ-023 SHALL continue reading on a controller ACK (SDA 0) and, on a NACK, release SDA and wait for STOP or START.
REQ-024 SHALL wrap the pointer from NREGS-1 to 0.
REQ-025 SHALL go to IDLE on STOP from any state, release sda_oe_o the next cycle and deassert busy_o.
REQ-026 SHALL give priority to a bus write over the local read when both address the same register in the same cycle; rd_data_o SHALL then show the new value one cycle later.

Reset
REQ-027 SHALL, while rst_i is high, hold sda_oe_o=0, wr_stb_o=0, busy_o=0, rd_data_o=0, all registers 8'h00, pointer 0 and state IDLE.
REQ-028 SHALL, when rst_i asserts mid-transfer, release SDA immediately and ignore the bus until the next START after reset deasserts.

Configuration
REQ-029 SHALL, with macro I2C_TARGET_AUTOINC_EN defined, increment the pointer after each written or read data byte.
REQ-030 SHALL, without I2C_TARGET_AUTOINC_EN, keep the pointer fixed within a transaction, so repeated reads return the same register and repeated writes overwrite it.

Verification
REQ-031 Bench SHALL cover: START, 0x72, 0x03, 0xA5, STOP -> three ACKs, reg[3]=0xA5, one wr_stb_o pulse with wr_addr_o=3, rd_addr_i=3 gives 0xA5.
REQ-032 Bench SHALL cover: with AUTOINC, write ptr 0x0F then 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22 (wrap).
REQ-033 Bench SHALL cover: write ptr 0x03, repeated START, 0x73, read 2 bytes ACK then NACK -> 0xA5, then reg[4] with AUTOINC or 0xA5 without; SDA released after the NACK.
REQ-034 Bench SHALL cover: START, 0x70 -> no ACK, sda_oe_o stays 0, busy_o stays 0, no wr_stb_o during following bytes.
REQ-035 Bench SHALL cover: rst_i pulse during the 4th bit of a read byte whose current bit is 0 -> sda_oe_o=0 within the same cycle, all registers 0x00.
REQ-036 Bench SHALL cover: STOP mid-byte after 4 data bits -> no register write, state IDLE, busy_o=0.
